// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction-fetch port, data port, memory
// command port and the pipeline stall.
//   slave  : arbiter side (takes requests, drives memory commands)
//   master : requester/memory side (CPU ports and the memory model)
interface mem_arbiter_if #(
  parameter int AW = 32
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  // data port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_ready;
  // memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  // pipeline freeze
  logic          stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port and the
// data port. One access at a time, round-robin on contention, fixed-latency
// memory (data valid LATENCY cycles after the mem_en strobe).
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : if_* fetch port, dm_* data port, mem_* memory port, stall
// Timeline for a grant in cycle T: mem_en in T+1, mem_rdata captured at the
// end of T+1+LATENCY, ready pulse in T+2+LATENCY.
module mem_arbiter #(
  parameter int LATENCY = 2,   // 1..15
  parameter int AW      = 32
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_dm_q, last_dm_d;   // 0: fetch was granted last
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic          el_i, el_d, gnt_i, gnt_d;

  // A port whose ready is high this cycle has been served; its req may still
  // be up for one more cycle and must not be issued again.
  assign el_i  = bus.if_req & ~if_ready_q;
  assign el_d  = bus.dm_req & ~dm_ready_q;
  // On contention the port not served last wins; after reset that is data.
  assign gnt_d = el_d & (~el_i | ~last_dm_q);
  assign gnt_i = el_i & ~gnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dm_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d     = BUSY_D;
          cnt_d       = '0;
          last_dm_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
        end else if (gnt_i) begin
          // fetch has no write data; mem_wdata keeps its old value
          state_d    = BUSY_I;
          cnt_d      = '0;
          last_dm_d  = 1'b0;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == LAT) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
            dm_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LATENCY=2 instance checked every cycle against a
// transaction-level model, plus LATENCY=1 and LATENCY=15 instances for the
// latency sweep. Directed scenarios carry literal cycle/data expectations.
module tb_mem_arbiter;
  localparam int LAT0 = 2;

  bit clock = 1'b0;
  bit reset = 1'b1;
  int cyc   = 0;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(32)) m  ();
  mem_arbiter_if #(.AW(32)) b1 ();
  mem_arbiter_if #(.AW(32)) b15();

  mem_arbiter #(.LATENCY(LAT0), .AW(32)) dut0 (.clock(clock), .reset(reset), .bus(m.slave));
  mem_arbiter #(.LATENCY(1),    .AW(32)) dut1 (.clock(clock), .reset(reset), .bus(b1.slave));
  mem_arbiter #(.LATENCY(15),   .AW(32)) dut15(.clock(clock), .reset(reset), .bus(b15.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // ---------------- memory model (shared contents, per-bus latency) -------
  bit [31:0] mem[256];
  bit        wr[256];

  function automatic logic [31:0] rdval(input logic [31:0] a);
    if (wr[a[9:2]]) return mem[a[9:2]];
    if (a == 32'h40) return 32'h2008_0005;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  int age0 = 0, age1 = 0, age15 = 0;
  always @(posedge clock) begin
    if (m.mem_en) begin
      age0 <= 1;
      if (m.mem_we) begin
        mem[m.mem_addr[9:2]] <= m.mem_wdata;
        wr[m.mem_addr[9:2]]  <= 1'b1;
      end
    end else if (age0 > 0 && age0 < LAT0) age0 <= age0 + 1;
    else age0 <= 0;
    if (b1.mem_en) age1 <= 1;
    else age1 <= 0;
    if (b15.mem_en) age15 <= 1;
    else if (age15 > 0 && age15 < 15) age15 <= age15 + 1;
    else age15 <= 0;
  end
  assign m.mem_rdata   = (age0  == LAT0) ? rdval(m.mem_addr)   : 32'hBADB_AD00;
  assign b1.mem_rdata  = (age1  == 1)    ? rdval(b1.mem_addr)  : 32'hBADB_AD01;
  assign b15.mem_rdata = (age15 == 15)   ? rdval(b15.mem_addr) : 32'hBADB_AD0F;

  // ---------------- transaction-level model + per-cycle compare -----------
  typedef struct {int c; logic we; logic [31:0] a; logic [31:0] wd;} en_t;
  en_t en_q[$];
  int  ifr_cnt = 0, stall_cnt = 0;
  bit  chk_en = 1'b0;

  int          own = 0;        // 0 none, 1 fetch, 2 data
  int          g = 0;          // grant cycle of the access in flight
  bit          last_dm = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0, e_ir = '0, e_dr = '0;
  logic        e_we = 1'b0, e_irdy = 1'b0, e_drdy = 1'b0;

  always @(negedge clock) begin : cmp
    logic e_en, e_stall, el_i, el_d;
    e_en    = (own != 0) && (cyc == g + 1);
    e_stall = (m.if_req && !e_irdy) || (m.dm_req && !e_drdy);
    if (chk_en) begin
      chk("mem_en",    {31'b0, m.mem_en},   {31'b0, e_en});
      chk("mem_we",    {31'b0, m.mem_we},   {31'b0, e_we});
      chk("mem_addr",  m.mem_addr,          e_addr);
      chk("mem_wdata", m.mem_wdata,         e_wd);
      chk("if_rdata",  m.if_rdata,          e_ir);
      chk("dm_rdata",  m.dm_rdata,          e_dr);
      chk("if_ready",  {31'b0, m.if_ready}, {31'b0, e_irdy});
      chk("dm_ready",  {31'b0, m.dm_ready}, {31'b0, e_drdy});
      chk("stall",     {31'b0, m.stall},    {31'b0, e_stall});
    end
    if (m.mem_en) en_q.push_back('{cyc, m.mem_we, m.mem_addr, m.mem_wdata});
    if (m.if_ready) ifr_cnt++;
    if (m.stall) stall_cnt++;

    // advance the model across the coming edge
    el_i = m.if_req && !e_irdy;
    el_d = m.dm_req && !e_drdy;
    if (reset) begin
      own = 0; last_dm = 1'b0;
      e_addr = '0; e_wd = '0; e_we = 1'b0; e_ir = '0; e_dr = '0;
      e_irdy = 1'b0; e_drdy = 1'b0;
    end else begin
      e_irdy = 1'b0;
      e_drdy = 1'b0;
      if (own != 0) begin
        if (cyc == g + 1 + LAT0) begin
          if (own == 1) begin
            e_ir = m.mem_rdata; e_irdy = 1'b1;
          end else begin
            if (!e_we) e_dr = m.mem_rdata;
            e_drdy = 1'b1;
          end
          own = 0;
        end
      end else if (el_d && (!el_i || !last_dm)) begin
        own = 2; g = cyc; last_dm = 1'b1;
        e_addr = m.dm_addr; e_we = m.dm_we; e_wd = m.dm_wdata;
      end else if (el_i) begin
        own = 1; g = cyc; last_dm = 1'b0;
        e_addr = m.if_addr; e_we = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Raise the selected requests now; drop each in its ready cycle, or one
  // cycle later when keep is set. Returns raise cycle and ready cycles.
  task automatic run(input bit ri, input bit rd, input bit keep,
                     output int t, output int ti, output int td);
    bit di, dd, done;
    t = cyc; ti = -1; td = -1; di = 0; dd = 0; done = 0;
    if (ri) m.if_req = 1'b1;
    if (rd) m.dm_req = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clock); #1;
      if (di) begin m.if_req = 1'b0; di = 0; end
      if (dd) begin m.dm_req = 1'b0; dd = 0; end
      if (ri && ti < 0 && m.if_ready) begin
        ti = cyc; if (keep) di = 1; else m.if_req = 1'b0;
      end
      if (rd && td < 0 && m.dm_ready) begin
        td = cyc; if (keep) dd = 1; else m.dm_req = 1'b0;
      end
      done = (!ri || ti >= 0) && (!rd || td >= 0) && !di && !dd;
    end
    if (!done) begin
      tmo("run");
      m.if_req = 1'b0; m.dm_req = 1'b0;
    end
  endtask

  // ---------------- directed scenarios -------------------------------------
  initial begin
    int t, ti, td, base;
    m.if_req = 0;  m.if_addr = 0;  m.dm_req = 0;  m.dm_we = 0;  m.dm_addr = 0;  m.dm_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
    b15.if_req = 0; b15.if_addr = 0; b15.dm_req = 0; b15.dm_we = 0; b15.dm_addr = 0; b15.dm_wdata = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_mem_en",   {31'b0, m.mem_en},   32'd0);
    chk("rst_mem_addr", m.mem_addr,          32'd0);
    chk("rst_if_rdata", m.if_rdata,          32'd0);
    chk("rst_dm_ready", {31'b0, m.dm_ready}, 32'd0);
    idle(1);

    // single fetch
    m.if_addr = 32'h40; en_q.delete(); stall_cnt = 0;
    run(1, 0, 0, t, ti, td);
    chk("fetch_ready_at", ti - t, 32'd4);
    chk("fetch_en_count", en_q.size(), 32'd1);
    if (en_q.size() > 0) begin
      chk("fetch_en_at",   en_q[0].c - t, 32'd1);
      chk("fetch_en_addr", en_q[0].a, 32'h40);
      chk("fetch_en_we",   {31'b0, en_q[0].we}, 32'd0);
    end
    chk("fetch_rdata", m.if_rdata, 32'h2008_0005);
    chk("fetch_stall_cycles", stall_cnt, 32'd4);
    idle(2);

    // store, then load it back
    m.dm_we = 1; m.dm_addr = 32'h100; m.dm_wdata = 32'hDEAD_BEEF; en_q.delete();
    run(0, 1, 0, t, ti, td);
    chk("store_ready_at", td - t, 32'd4);
    chk("store_en_count", en_q.size(), 32'd1);
    if (en_q.size() > 0) begin
      chk("store_en_at",    en_q[0].c - t, 32'd1);
      chk("store_en_we",    {31'b0, en_q[0].we}, 32'd1);
      chk("store_en_addr",  en_q[0].a, 32'h100);
      chk("store_en_wdata", en_q[0].wd, 32'hDEAD_BEEF);
    end
    chk("store_dm_rdata_kept", m.dm_rdata, 32'd0);
    idle(1);
    m.dm_we = 0;
    run(0, 1, 0, t, ti, td);
    chk("load_back", m.dm_rdata, 32'hDEAD_BEEF);
    idle(2);

    // contention right after reset: data first, fetch back-to-back
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("rst2_if_rdata", m.if_rdata, 32'd0);
    chk("rst2_dm_rdata", m.dm_rdata, 32'd0);
    m.if_addr = 32'h200; m.dm_addr = 32'h104; en_q.delete();
    run(1, 1, 0, t, ti, td);
    chk("pair1_dm_ready_at", td - t, 32'd4);
    chk("pair1_if_ready_at", ti - t, 32'd8);
    chk("pair1_en_count", en_q.size(), 32'd2);
    if (en_q.size() > 1) begin
      chk("pair1_en0_at",   en_q[0].c - t, 32'd1);
      chk("pair1_en0_addr", en_q[0].a, 32'h104);
      chk("pair1_en1_at",   en_q[1].c - t, 32'd5);
      chk("pair1_en1_addr", en_q[1].a, 32'h200);
    end
    chk("pair1_if_rdata", m.if_rdata, 32'hC0DE_0200);
    idle(1);
    m.dm_addr = 32'h108;
    run(0, 1, 0, t, ti, td);
    idle(1);
    // data was served last, so fetch wins this pair
    run(1, 1, 0, t, ti, td);
    chk("pair2_if_ready_at", ti - t, 32'd4);
    chk("pair2_dm_ready_at", td - t, 32'd8);
    idle(2);

    // stale request held through the ready cycle
    m.if_addr = 32'h80; en_q.delete(); base = ifr_cnt;
    run(1, 0, 1, t, ti, td);
    idle(4);
    chk("stale_en_count", en_q.size(), 32'd1);
    chk("stale_ready_count", ifr_cnt - base, 32'd1);

    // latency sweep
    b1.dm_addr = 32'h40; b1.dm_req = 1'b1; t = cyc; ti = -1;
    for (int n = 0; n < 40 && ti < 0; n++) begin
      @(posedge clock); #1;
      if (b1.dm_ready) ti = cyc;
    end
    b1.dm_req = 1'b0;
    if (ti < 0) tmo("lat1_ready");
    else chk("lat1_ready_at", ti - t, 32'd3);
    chk("lat1_rdata", b1.dm_rdata, 32'h2008_0005);
    b15.dm_addr = 32'h100; b15.dm_req = 1'b1; t = cyc; ti = -1;
    for (int n = 0; n < 40 && ti < 0; n++) begin
      @(posedge clock); #1;
      if (b15.dm_ready) ti = cyc;
    end
    b15.dm_req = 1'b0;
    if (ti < 0) tmo("lat15_ready");
    else chk("lat15_ready_at", ti - t, 32'd17);
    chk("lat15_rdata", b15.dm_rdata, 32'hDEAD_BEEF);
    idle(2);

    // reset in the middle of a fetch
    m.if_addr = 32'h40; m.if_req = 1'b1; t = cyc; base = ifr_cnt;
    idle(2);
    reset = 1'b1; m.if_req = 1'b0;
    idle(1);
    chk("rstmid_at", cyc - t, 32'd3);
    chk("rstmid_mem_en",   {31'b0, m.mem_en},   32'd0);
    chk("rstmid_mem_addr", m.mem_addr,          32'd0);
    chk("rstmid_if_rdata", m.if_rdata,          32'd0);
    chk("rstmid_if_ready", {31'b0, m.if_ready}, 32'd0);
    reset = 1'b0;
    idle(8);
    chk("rstmid_no_ready", ifr_cnt - base, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
